// File: rtl/npu_pe_pkg.sv
// Shared opcode encoding and arithmetic helpers for the NPU processing-element array.
// SAT_W is a wide scratch width that holds any intermediate sum or product without loss.
package npu_pe_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_MAC   = 4'd4,
        OP_MACZ  = 4'd5,
        OP_ACCRD = 4'd6
    } pe_op_e;

    // Must exceed 2*DATA_WIDTH+1 and ACC_WIDTH+1 so no intermediate value ever wraps.
    localparam int SAT_W = 128;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovf;
    } sat_res_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd6);
    endfunction

    // Reduce a wide signed value to 'width' bits. The returned value is sign-extended
    // back to SAT_W; ovf flags any clamp or wrap loss.
    function automatic sat_res_t sat_trunc(input logic signed [SAT_W-1:0] value,
                                           input int width,
                                           input logic saturate);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] wrapped;
        sat_res_t r;
        max_v   = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        min_v   = ~max_v;
        wrapped = value <<< (SAT_W - width);
        wrapped = wrapped >>> (SAT_W - width);
        r.ovf   = (value > max_v) || (value < min_v);
        if (!r.ovf) begin
            r.value = value;
        end else if (saturate) begin
            r.value = (value > max_v) ? max_v : min_v;
        end else begin
            r.value = wrapped;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_array_pipelined_lane.sv
// One lane of the PE array: S1 operand/product registers, S2 arithmetic, result register
// and the lane's private accumulator.
module pe_lane
    import npu_pe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  commit,
    input  logic                  acc_clr,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf
);

    logic signed [DATA_WIDTH-1:0]   a_q;
    logic signed [DATA_WIDTH-1:0]   b_q;
    logic signed [2*DATA_WIDTH-1:0] prod_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    logic signed [SAT_W-1:0] a_ext;
    logic signed [SAT_W-1:0] b_ext;
    logic signed [SAT_W-1:0] prod_ext;
    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] acc_base;
    logic signed [SAT_W-1:0] wide;
    sat_res_t                acc_sat;
    sat_res_t                res_sat;
    logic                    unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else if (load) begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        end
    end

    assign a_ext    = {{(SAT_W-DATA_WIDTH){a_q[DATA_WIDTH-1]}}, a_q};
    assign b_ext    = {{(SAT_W-DATA_WIDTH){b_q[DATA_WIDTH-1]}}, b_q};
    assign prod_ext = {{(SAT_W-2*DATA_WIDTH){prod_q[2*DATA_WIDTH-1]}}, prod_q};
    assign acc_ext  = {{(SAT_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};

    // A clear arriving with a committing beat is applied before that beat's accumulate.
    assign acc_base = acc_clr ? '0 : acc_ext;

    always_comb begin
        acc_sat = {acc_base, 1'b0};
        wide    = '0;
        case (op)
            OP_ADD:   wide = a_ext + b_ext;
            OP_SUB:   wide = a_ext - b_ext;
            OP_MUL:   wide = prod_ext;
            OP_MAC: begin
                acc_sat = sat_trunc(acc_base + prod_ext, ACC_WIDTH, SATURATE != 0);
                wide    = acc_sat.value;
            end
            OP_MACZ: begin
                acc_sat = sat_trunc(prod_ext, ACC_WIDTH, SATURATE != 0);
                wide    = acc_sat.value;
            end
            OP_ACCRD: wide = acc_ext;
            default:  wide = '0;
        endcase
        res_sat = sat_trunc(wide, DATA_WIDTH, SATURATE != 0);
    end

    assign unused_bits = ^{res_sat.value[SAT_W-1:DATA_WIDTH], acc_sat.value[SAT_W-1:ACC_WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (commit) begin
            acc_q <= acc_sat.value[ACC_WIDTH-1:0];
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ovf    <= 1'b0;
        end else if (commit) begin
            result <= res_sat.value[DATA_WIDTH-1:0];
            ovf    <= res_sat.ovf | acc_sat.ovf;
        end
    end

endmodule

// File: rtl/pe_array_pipelined.sv
// Multi-lane NPU processing element: two-stage pipeline with valid/ready on both sides.
// This level owns stall control, the stage valid bits, the shared S1 opcode and op_err.
module pe_array_pipelined
    import npu_pe_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int SATURATE   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_op,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    input  logic                        acc_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_result,
    output logic [LANES-1:0]            out_ovf,
    output logic                        op_err
);

    // Handshake: a beat moves on a side whenever valid && ready are both high at the clock
    // edge; a producer holds valid and payload until that happens, and out_* stay frozen
    // while out_valid && !out_ready.
    logic       s1_valid;
    logic       s2_valid;
    logic [3:0] s1_op;
    logic       advance;
    logic       load;
    logic       commit;

    assign advance   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || advance;
    assign load      = in_valid && in_ready;
    assign commit    = s1_valid && advance;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_op    <= '0;
            op_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (advance) begin
                s2_valid <= s1_valid;
            end
            if (load) begin
                s1_op <= in_op;
            end
            if (load && !op_legal(in_op)) begin
                op_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .commit  (commit),
            .acc_clr (acc_clr),
            .op      (s1_op),
            .a       (in_a[i*DATA_WIDTH +: DATA_WIDTH]),
            .b       (in_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .result  (out_result[i*DATA_WIDTH +: DATA_WIDTH]),
            .ovf     (out_ovf[i])
        );
    end

endmodule
